exu_multicycle: RTL

//  Parametrised multi-cycle execute unit; successor to the single-op EXU.

---
 rtl/exu_multicycle.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/exu_multicycle.sv
// Multi-cycle execute unit: single-cycle integer ALU plus iterative
// shift-add MUL (low half) and restoring DIVU/REMU, each DATA_WIDTH steps.
// valid/ready on both sides, registered write-back triple.
module exu_multicycle #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  use_imm,
    input  logic [ADDR_WIDTH-1:0] des_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wen,
    output logic [ADDR_WIDTH-1:0] out_waddr,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  busy
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CNW = SHW + 1;

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_PASSB = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(13);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_wen_q, out_wen_d;
    logic [ADDR_WIDTH-1:0] out_waddr_q, out_waddr_d;
    logic [DATA_WIDTH-1:0] out_wdata_q, out_wdata_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // a: multiplicand (shifted left) or divisor; b: multiplier (shifted
    // right) or dividend/quotient (shifted left); acc: product or remainder
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNW-1:0]        cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] opb;
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  in_wen;
    logic [DATA_WIDTH-1:0] mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_trial;
    logic                  div_ok;
    logic [DATA_WIDTH-1:0] div_rem;
    logic [DATA_WIDTH-1:0] div_quo;
    logic                  it_wen;

    assign opb    = use_imm ? imm : src2;
    assign shamt  = opb[SHW-1:0];
    assign in_wen = (des_addr != '0) && (op <= OP_REMU);

    // One iteration of shift-add multiply and restoring divide. A zero
    // divisor never fails the trial subtract, giving all-ones / A for free.
    assign mul_sum   = acc_q + (b_q[0] ? a_q : '0);
    assign div_shift = {acc_q, b_q[DATA_WIDTH-1]};
    assign div_trial = div_shift - {1'b0, a_q};
    assign div_ok    = ~div_trial[DATA_WIDTH];
    assign div_rem   = div_ok ? div_trial[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    assign div_quo   = {b_q[DATA_WIDTH-2:0], div_ok};
    assign it_wen    = (addr_q != '0);

    // Single-cycle ALU on the presented operands; undefined ops yield zero
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:   alu_res = src1 + opb;
            OP_SUB:   alu_res = src1 - opb;
            OP_AND:   alu_res = src1 & opb;
            OP_OR:    alu_res = src1 | opb;
            OP_XOR:   alu_res = src1 ^ opb;
            OP_SLL:   alu_res = src1 << shamt;
            OP_SRL:   alu_res = src1 >> shamt;
            OP_SRA:   alu_res = $signed(src1) >>> shamt;
            OP_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1) < $signed(opb))};
            OP_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (src1 < opb)};
            OP_PASSB: alu_res = opb;
            default:  alu_res = '0;
        endcase
    end

    // Next-state and next-output logic for the IDLE/MUL/DIV/DONE controller
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_wen_d   = out_wen_q;
        out_waddr_d = out_waddr_q;
        out_wdata_d = out_wdata_q;
        op_d        = op_q;
        addr_d      = addr_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d   = op;
                    addr_d = des_addr;
                    acc_d  = '0;
                    cnt_d  = CNW'(DATA_WIDTH);
                    if (op == OP_MUL) begin
                        a_d     = src1;
                        b_d     = opb;
                        state_d = S_MUL;
                    end else if (op == OP_DIVU || op == OP_REMU) begin
                        a_d     = opb;
                        b_d     = src1;
                        state_d = S_DIV;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_wen_d   = in_wen;
                        out_waddr_d = in_wen ? des_addr : '0;
                        out_wdata_d = alu_res;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNW'(1);
                // Final step publishes the result directly so valid rises
                // exactly DATA_WIDTH edges after the accept edge
                if (cnt_q == CNW'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_wen_d   = it_wen;
                    out_waddr_d = it_wen ? addr_q : '0;
                    out_wdata_d = mul_sum;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                b_d   = div_quo;
                cnt_d = cnt_q - CNW'(1);
                if (cnt_q == CNW'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_wen_d   = it_wen;
                    out_waddr_d = it_wen ? addr_q : '0;
                    out_wdata_d = (op_q == OP_REMU) ? div_rem : div_quo;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    assign in_ready_d = (state_d == S_IDLE);
    assign busy_d     = (state_d == S_MUL) || (state_d == S_DIV);

    // State, datapath and registered outputs; reset drops any operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_wen_q   <= 1'b0;
            out_waddr_q <= '0;
            out_wdata_q <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_wen_q   <= out_wen_d;
            out_waddr_q <= out_waddr_d;
            out_wdata_q <= out_wdata_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_wen   = out_wen_q;
    assign out_waddr = out_waddr_q;
    assign out_wdata = out_wdata_q;

endmodule
